// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM LED generator and its upstream duty controller.
// Holds the frame/duty width defaults and the ramp state encoding.
package pwm_pkg;

   localparam int DEF_SW_W        = 4;
   localparam int DEF_CBITS       = 15;
   localparam int DEF_DEB_CYCLES  = 50000;
   localparam int DEF_STEP_FRAMES = 4;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RAMP_UP   = 2'd1,
      RAMP_DOWN = 2'd2
   } ramp_state_e;

   // Direction the duty code must move to reach the target.
   function automatic ramp_state_e ramp_dir(input logic [31:0] cur, input logic [31:0] tgt);
      if (cur < tgt) begin
         return RAMP_UP;
      end else if (cur > tgt) begin
         return RAMP_DOWN;
      end
      return IDLE;
   endfunction

endpackage : pwm_pkg

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus whole-vector debounce for the switch bank.
// Also exposes the value sw_stable will take at the next edge.
module sw_debounce
   import pwm_pkg::*;
#(
   parameter int SW_W       = DEF_SW_W,
   parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [SW_W-1:0] i_sw_raw,
   output logic [SW_W-1:0] o_sw_stable,
   output logic [SW_W-1:0] o_sw_stable_nxt
);

   localparam int            CW       = $clog2(DEB_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   if (DEB_CYCLES < 2) begin : g_bad_deb
      $error("sw_debounce: DEB_CYCLES must be at least 2");
   end

   logic [SW_W-1:0] r_sync1;
   logic [SW_W-1:0] r_sync2;
   logic [SW_W-1:0] r_cand;
   logic [SW_W-1:0] r_stable;
   logic [CW-1:0]   r_cnt;
   logic            w_match;
   logic            w_load;

   assign w_match         = (r_sync2 == r_cand);
   assign w_load          = w_match && !(r_cnt < CNT_LAST);
   assign o_sw_stable_nxt = w_load ? r_cand : r_stable;
   assign o_sw_stable     = r_stable;

   // NOTE: non-blocking assignments let every flop sample the pre-edge value,
   // which is what makes r_sync1 -> r_sync2 a real two-stage chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1  <= '0;
         r_sync2  <= '0;
         r_cand   <= '0;
         r_cnt    <= '0;
         r_stable <= '0;
      end else begin
         r_sync1  <= i_sw_raw;
         r_sync2  <= r_sync1;
         r_stable <= o_sw_stable_nxt;
         if (!w_match) begin
            r_cand <= r_sync2;
            r_cnt  <= '0;
         end else if (r_cnt < CNT_LAST) begin
            r_cnt <= r_cnt + CNT_ONE;
         end
      end
   end

endmodule : sw_debounce

// File: rtl/pwm_duty_ctrl.sv
// Duty-code controller: debounced target, frame-aligned strobe and a slewed
// duty ramp that only moves in the cycle after a frame start.
module pwm_duty_ctrl
   import pwm_pkg::*;
#(
   parameter int SW_W        = DEF_SW_W,
   parameter int CBITS       = DEF_CBITS,
   parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
   parameter int STEP_FRAMES = DEF_STEP_FRAMES
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [SW_W-1:0] sw_raw,
   output logic [SW_W-1:0] duty_code,
   output logic [SW_W-1:0] sw_stable,
   output logic            frame_start,
   output logic            busy
);

   localparam int               SCW        = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
   localparam logic [SCW-1:0]   STEP_LAST  = SCW'(STEP_FRAMES - 1);
   localparam logic [SCW-1:0]   STEP_ONE   = SCW'(1);
   localparam logic [CBITS-1:0] FRAME_ONE  = CBITS'(1);
   localparam logic [SW_W-1:0]  DUTY_ONE   = SW_W'(1);

   if (STEP_FRAMES < 1) begin : g_bad_step
      $error("pwm_duty_ctrl: STEP_FRAMES must be at least 1");
   end

   logic [SW_W-1:0]  w_stable;
   logic [SW_W-1:0]  w_stable_nxt;
   logic [CBITS-1:0] r_frame_cnt;
   logic             r_frame_start;
   logic [SCW-1:0]   r_step_cnt;
   logic             w_step_edge;
   logic [SW_W-1:0]  r_duty;
   logic [SW_W-1:0]  w_duty_nxt;
   ramp_state_e      r_state;
   ramp_state_e      w_state_nxt;

   sw_debounce #(
      .SW_W       (SW_W),
      .DEB_CYCLES (DEB_CYCLES)
   ) u_sw_debounce (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_sw_raw        (sw_raw),
      .o_sw_stable     (w_stable),
      .o_sw_stable_nxt (w_stable_nxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_frame_cnt   <= '0;
         r_frame_start <= 1'b0;
         r_step_cnt    <= '0;
      end else begin
         r_frame_cnt   <= r_frame_cnt + FRAME_ONE;
         r_frame_start <= &r_frame_cnt;
         if (r_frame_start) begin
            r_step_cnt <= (r_step_cnt == STEP_LAST) ? '0 : r_step_cnt + STEP_ONE;
         end
      end
   end

   assign w_step_edge = r_frame_start && (r_step_cnt == STEP_LAST);

   // State is computed from the next duty/target pair, so r_state always
   // matches the current registers and a step can never overshoot.
   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      w_duty_nxt = r_duty;
      if (w_step_edge) begin
         unique case (r_state)
            RAMP_UP:   w_duty_nxt = r_duty + DUTY_ONE;
            RAMP_DOWN: w_duty_nxt = r_duty - DUTY_ONE;
            default:   w_duty_nxt = r_duty;
         endcase
      end
      w_state_nxt = ramp_dir(32'(w_duty_nxt), 32'(w_stable_nxt));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_duty  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_duty  <= w_duty_nxt;
      end
   end

   assign duty_code   = r_duty;
   assign sw_stable   = w_stable;
   assign frame_start = r_frame_start;
   assign busy        = (r_state != IDLE);

endmodule : pwm_duty_ctrl
